// File: rtl/imem_loader_pkg.sv
// Shared state encoding and word-format constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0007_8000;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte-to-word packer: shifts bytes in MSB-first, counts bytes within the current word.
// Latency: word updates on the accepting edge; last_byte flags that the next shift completes a word.
// Backpressure: none of its own; the caller gates shift with the handshake.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               last_byte
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word <= '0;
      cnt  <= '0;
    end else begin
      if (shift) word <= {word[INSTR_W-9:0], data};
      // Counter wraps naturally to 0 after the final byte of a word.
      if (clear)      cnt <= '0;
      else if (shift) cnt <= cnt + 1'b1;
    end
  end

  assign last_byte = (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as MSB-first 32-bit words at addresses 0..LOAD_WORDS-1.
// Latency: im_we one cycle after the 4th byte; done one cycle after the last write (or trailer with LOADER_CHECKSUM_EN).
// Backpressure: in_ready low outside RECV/CHECK and during the write cycle; in_valid gaps stall indefinitely.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int LOAD_WORDS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wd,
  output logic               busy,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_WORDS - 1);

  state_t state, next_state;
  logic   xfer, start_load, last_byte, last_addr;

  assign xfer      = in_valid & in_ready;
  assign last_addr = (im_addr == LAST_ADDR);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_load),
    .shift     (xfer && state == RECV),
    .data      (in_data),
    .word      (im_wd),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    im_we      = 1'b0;
    busy       = 1'b0;
    start_load = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RECV;
          start_load = 1'b1;
        end
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte) next_state = WRITE;
      end
      WRITE: begin
        im_we = 1'b1;
        busy  = 1'b1;
        if (last_addr) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) next_state = DONE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign cpu_hold = busy;
  assign done     = (state == DONE);

  // Address stops at LAST_ADDR; the load ends there rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       im_addr <= '0;
    else if (start_load)              im_addr <= '0;
    else if (state == WRITE && !last_addr) im_addr <= im_addr + 1'b1;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (start_load) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (xfer && state == RECV) begin
      csum <= csum ^ in_data;
    end else if (xfer && state == CHECK) begin
      err_q <= (in_data != csum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances (LOAD_WORDS 1, 2, 64) share one stimulus stream.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic [2:0]  rdy, we, bsy, hold, dn, er;
  logic [5:0]  addr [3];
  logic [31:0] wd   [3];

  int total = 0;
  int bad   = 0;

  logic [5:0]  q1a[$], q2a[$], q64a[$];
  logic [31:0] q1d[$], q2d[$], q64d[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6), .LOAD_WORDS(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .im_we(we[0]), .im_addr(addr[0]), .im_wd(wd[0]),
    .busy(bsy[0]), .cpu_hold(hold[0]), .done(dn[0]), .err(er[0]));

  imem_loader #(.ADDR_W(6), .LOAD_WORDS(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .im_we(we[1]), .im_addr(addr[1]), .im_wd(wd[1]),
    .busy(bsy[1]), .cpu_hold(hold[1]), .done(dn[1]), .err(er[1]));

  imem_loader #(.ADDR_W(6), .LOAD_WORDS(64)) u64 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .im_we(we[2]), .im_addr(addr[2]), .im_wd(wd[2]),
    .busy(bsy[2]), .cpu_hold(hold[2]), .done(dn[2]), .err(er[2]));

  // Record every write pulse away from the active edge.
  always @(negedge clk) begin
    if (we[0]) begin q1a.push_back(addr[0]);  q1d.push_back(wd[0]);  end
    if (we[1]) begin q2a.push_back(addr[1]);  q2d.push_back(wd[1]);  end
    if (we[2]) begin q64a.push_back(addr[2]); q64d.push_back(wd[2]); end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    reset = 1'b1;
    tick();
    q1a.delete(); q1d.delete(); q2a.delete(); q2d.delete(); q64a.delete(); q64d.delete();
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte after `gap` idle cycles; returns #1 after its transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input int sel);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!rdy[sel] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles expected 1 (sel=%0d)", sel);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input int sel);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24], gap, sel);
    send_byte(t[23:16], gap, sel);
    send_byte(t[15:8],  gap, sel);
    send_byte(t[7:0],   gap, sel);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  trailer;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];
  logic exp_e;

  initial begin
    vecs[0] = '{word: 32'h80080001, trailer: 8'h89, exp_err: 1'b0};
    vecs[1] = '{word: 32'h80080001, trailer: 8'h00, exp_err: 1'b1};
    vecs[2] = '{word: 32'hAABBCCDD, trailer: 8'h00, exp_err: 1'b0};
    vecs[3] = '{word: 32'h00078000, trailer: 8'h86, exp_err: 1'b1};
    vecs[4] = '{word: 32'hFFFFFFFF, trailer: 8'h00, exp_err: 1'b0};

    // Reset state, observed while reset is still asserted.
    tick();
    check("rst_in_ready", {29'd0, rdy}, 32'd0);
    check("rst_we",       {29'd0, we},  32'd0);
    check("rst_busy",     {29'd0, bsy}, 32'd0);
    check("rst_hold",     {29'd0, hold}, 32'd0);
    check("rst_done",     {29'd0, dn},  32'd0);
    check("rst_err",      {29'd0, er},  32'd0);
    check("rst_addr",     {26'd0, addr[0]}, 32'd0);
    check("rst_wd",       wd[0], 32'd0);

    // Single-word loads, back-to-back bytes.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      pulse_start();
      check("t1_busy_on", {31'd0, bsy[0]},  32'd1);
      check("t1_hold_on", {31'd0, hold[0]}, 32'd1);
      send_word(vecs[i].word, 0, 0);
      check("t1_we",   {31'd0, we[0]}, 32'd1);
      check("t1_addr", {26'd0, addr[0]}, 32'd0);
      check("t1_wd",   wd[0], vecs[i].word);
      check("t1_done_during_write", {31'd0, dn[0]}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
      tick();
      send_byte(vecs[i].trailer, 0, 0);
      exp_e = vecs[i].exp_err;
`else
      tick();
      exp_e = 1'b0;
`endif
      check("t1_done",     {31'd0, dn[0]},   32'd1);
      check("t1_busy_off", {31'd0, bsy[0]},  32'd0);
      check("t1_hold_off", {31'd0, hold[0]}, 32'd0);
      check("t1_err",      {31'd0, er[0]},   {31'd0, exp_e});
      repeat (3) tick();
      check("t1_done_held", {31'd0, dn[0]}, 32'd1);
      check("t1_nwrites", q1a.size(), 32'd1);
    end

    // Two words with 3-cycle in_valid gaps.
    do_reset();
    pulse_start();
    send_word(32'h82100001, 3, 1);
    check("t2_we0",   {31'd0, we[1]}, 32'd1);
    check("t2_addr0", {26'd0, addr[1]}, 32'd0);
    check("t2_wd0",   wd[1], 32'h82100001);
    send_word(32'h021D0400, 3, 1);
    check("t2_we1",   {31'd0, we[1]}, 32'd1);
    check("t2_addr1", {26'd0, addr[1]}, 32'd1);
    check("t2_wd1",   wd[1], 32'h021D0400);
`ifdef LOADER_CHECKSUM_EN
    tick();
    send_byte(8'h88, 0, 1);
    check("t2_err", {31'd0, er[1]}, 32'd0);
`else
    tick();
`endif
    check("t2_done", {31'd0, dn[1]}, 32'd1);
    repeat (5) tick();
    check("t2_nwrites", q2a.size(), 32'd2);

    // Reset in the middle of the second word.
    do_reset();
    pulse_start();
    send_word(32'h11223344, 0, 1);
    tick();
    send_byte(8'h55, 0, 1);
    send_byte(8'h66, 0, 1);
    reset = 1'b0;
    #1;
    check("t3_done_rst", {31'd0, dn[1]},  32'd0);
    check("t3_err_rst",  {31'd0, er[1]},  32'd0);
    check("t3_busy_rst", {31'd0, bsy[1]}, 32'd0);
    check("t3_addr_rst", {26'd0, addr[1]}, 32'd0);
    check("t3_wd_rst",   wd[1], 32'd0);
    check("t3_writes_before", q2a.size(), 32'd1);
    tick(); tick();
    reset = 1'b1;
    tick();
    q2a.delete(); q2d.delete();
    pulse_start();
    send_word(32'hAABBCCDD, 0, 1);
    check("t3_we",   {31'd0, we[1]}, 32'd1);
    check("t3_addr", {26'd0, addr[1]}, 32'd0);
    check("t3_wd",   wd[1], 32'hAABBCCDD);

    // start mid-load is ignored.
    do_reset();
    pulse_start();
    send_byte(8'hDE, 0, 2);
    send_byte(8'hAD, 0, 2);
    pulse_start();
    check("t4_busy", {31'd0, bsy[2]}, 32'd1);
    send_byte(8'hBE, 0, 2);
    send_byte(8'hEF, 0, 2);
    check("t4_we0",   {31'd0, we[2]}, 32'd1);
    check("t4_addr0", {26'd0, addr[2]}, 32'd0);
    check("t4_wd0",   wd[2], 32'hDEADBEEF);
    tick();
    pulse_start();
    send_word(32'h01020304, 0, 2);
    check("t4_addr1", {26'd0, addr[2]}, 32'd1);
    check("t4_wd1",   wd[2], 32'h01020304);

    // Full 64-word load with a counting byte pattern.
    do_reset();
    pulse_start();
    for (int w = 0; w < 64; w++) begin
      logic [7:0] b0;
      b0 = 8'(w * 4);
      send_word({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, 0, 2);
      tick();
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0, 2);
    check("t6_err", {31'd0, er[2]}, 32'd0);
`endif
    check("t6_done", {31'd0, dn[2]}, 32'd1);
    check("t6_last_addr", {26'd0, addr[2]}, 32'd63);
    repeat (3) tick();
    check("t6_nwrites", q64a.size(), 32'd64);
    for (int k = 0; k < 64 && k < q64a.size(); k++) begin
      logic [7:0] e0;
      e0 = 8'(k * 4);
      check("t6_addr", {26'd0, q64a[k]}, k);
      check("t6_wd",   q64d[k], {e0, e0 + 8'd1, e0 + 8'd2, e0 + 8'd3});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
